firebird7_in_gate1_tessent_tdr_data_ctrl_w3: RTL and testbench
==============================================================

Name: firebird7_in_gate1_tessent_tdr_data_ctrl_w3

Overview:
IJTAG test data register that drives the select/data side of the gate1 functional/IJTAG data muxes. It captures functional data for observation and shifts between ijtag_si and ijtag_so. On update, it loads a shadow register that drives ijtag_select and ijtag_data_out. A shift-length checker blocks updates after a wrong-length scan and reports the fault as a read-clear sticky bit.

Parameters:
DATA_WIDTH, 3, width of functional/IJTAG data path; scan length L = DATA_WIDTH+1
CNT_WIDTH, 4, shift counter width; must satisfy 2^CNT_WIDTH-1 > L; counter saturates

Ports:
ijtag_tck  input  1  sole clock, all state on rising edge
ijtag_reset  input  1  synchronous, active-high reset
ijtag_sel  input  1  register selected in active scan path
ijtag_ce  input  1  capture enable
ijtag_se  input  1  shift enable
ijtag_ue  input  1  update enable
ijtag_si  input  1  scan in
ijtag_so  output  1  scan out = shift_reg[0], registered
functional_data_in  input  DATA_WIDTH  functional value observed at capture
ijtag_data_out  output  DATA_WIDTH  shadow data to mux ijtag_data_in
ijtag_select  output  1  shadow select to mux ijtag_select
length_error  output  1  sticky flag: last update rejected or enables collided

Behaviour:
- Shift register layout sr[L-1:0]: sr[0] = select/status bit, sr[DATA_WIDTH:1] = data.
- Reset (ijtag_reset=1 at edge): sr=0, shadow data=0, ijtag_select=0, count=0, length_error=0, state=IDLE. The functional path is selected from reset. Reset overrides all enables, including mid-scan.
- Enables take effect only when ijtag_sel=1. With ijtag_sel=0, all state holds.
- Capture (ce): sr[DATA_WIDTH:1] <= functional_data_in; sr[0] <= length_error; count <= 0; length_error <= 0 (read-clear); state <= CAPTURED.
- Shift (se): sr <= {ijtag_si, sr[L-1:1]}. The LSB exits first on ijtag_so and is visible the cycle after each shift. count <= count+1, saturating at all-ones. state <= SHIFT.
- Update (ue):
  - Valid update requires state == SHIFT and count == L. It loads ijtag_select <= sr[0] and ijtag_data_out <= sr[DATA_WIDTH:1]. Outputs change one cycle after the ue edge.
  - Any other update (count != L, including 0 or saturated, or state != SHIFT) leaves the shadow unchanged and sets length_error.
  - Every update sets count <= 0 and state <= IDLE.
- Simultaneous enables with sel: priority is ce > se > ue. Only the highest-priority action executes and length_error is set. When ce wins, the sticky bit is set after the read-clear, so it stays 1.
- States: IDLE -ce-> CAPTURED -se-> SHIFT -se-> SHIFT -ue-> IDLE. ce from any state -> CAPTURED. ue from IDLE/CAPTURED is an error and returns to IDLE.
- Shadow outputs only change on a valid update or on reset. Capture and shift never disturb ijtag_select or ijtag_data_out.
- ijtag_so is stable while se=0.

Test Plan:
- Reset then idle 5 cycles -> ijtag_select=0, ijtag_data_out=3'b000, length_error=0, ijtag_so=0.
- Capture with functional_data_in=3'b101, then 4 shifts with si=0 -> so sequence 0,1,0,1 (bit0, then data LSB first); shadow unchanged.
- Capture, shift in 1,1,0,1 (si LSB first), then ue -> next cycle ijtag_select=1, ijtag_data_out=3'b101, length_error=0.
- Capture, 3 shifts, ue -> shadow retains prior value, length_error=1. Next capture loads sr[0]=1 and clears length_error to 0.
- ce and ue asserted together with sel=1 -> capture performed, shadow unchanged, length_error=1. Also: any enable with sel=0 -> no state change.
- ijtag_reset asserted after 2 of 4 shifts -> all outputs 0 next cycle. A following ue without capture -> shadow stays 0, length_error=1.

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_tdr_data_ctrl_w3.sv
// IJTAG test data register for the gate1 functional/IJTAG data muxes: capture/shift/update
// with a shadow register and a shift-length checker that reports faults as a read-clear sticky bit.
module firebird7_in_gate1_tessent_tdr_data_ctrl_w3 #(
    parameter int DATA_WIDTH = 3,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  ijtag_tck,
    input  logic                  ijtag_reset,
    input  logic                  ijtag_sel,
    input  logic                  ijtag_ce,
    input  logic                  ijtag_se,
    input  logic                  ijtag_ue,
    input  logic                  ijtag_si,
    output logic                  ijtag_so,
    input  logic [DATA_WIDTH-1:0] functional_data_in,
    output logic [DATA_WIDTH-1:0] ijtag_data_out,
    output logic                  ijtag_select,
    output logic                  length_error,
    output logic [1:0]            dbg_state
);

    localparam int L = DATA_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_LEN = CNT_WIDTH'(L);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CAPTURED = 2'd1,
        S_SHIFT    = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [L-1:0]          sr_q, sr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  select_q, select_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  collision;

    // Handshake: no valid/ready here; ce/se/ue act on a rising tck edge only while ijtag_sel=1,
    // with priority ce > se > ue. More than one enable at once is flagged as a length error.
    assign collision = (ijtag_ce & ijtag_se) | (ijtag_ce & ijtag_ue) | (ijtag_se & ijtag_ue);

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        data_d   = data_q;
        select_d = select_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        if (ijtag_sel) begin
            if (ijtag_ce) begin
                // Old sticky bit is shifted out as status; a colliding capture re-arms it.
                sr_d    = {functional_data_in, err_q};
                cnt_d   = '0;
                err_d   = collision;
                state_d = S_CAPTURED;
            end else if (ijtag_se) begin
                sr_d    = {ijtag_si, sr_q[L-1:1]};
                cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                state_d = S_SHIFT;
                if (collision) begin
                    err_d = 1'b1;
                end
            end else if (ijtag_ue) begin
                if (state_q == S_SHIFT && cnt_q == CNT_LEN) begin
                    select_d = sr_q[0];
                    data_d   = sr_q[DATA_WIDTH:1];
                end else begin
                    err_d = 1'b1;
                end
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            state_q  <= S_IDLE;
            sr_q     <= '0;
            data_q   <= '0;
            select_q <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            data_q   <= data_d;
            select_q <= select_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign ijtag_so       = sr_q[0];
    assign ijtag_data_out = data_q;
    assign ijtag_select   = select_q;
    assign length_error   = err_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_data_ctrl_w3.sv
// Directed bench for the gate1 IJTAG data TDR: capture/shift/update, length faults,
// enable collisions, deselect hold, reset mid-scan and counter saturation.
module tb_firebird7_in_gate1_tessent_tdr_data_ctrl_w3;

    logic       tck = 1'b0;
    logic       rst;
    logic       sel, ce, se, ue, si;
    logic       so;
    logic [2:0] fdi;
    logic [2:0] dout;
    logic       isel;
    logic       lerr;
    logic [1:0] st;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CAP  = 2'd1;
    localparam logic [1:0] ST_SH   = 2'd2;

    firebird7_in_gate1_tessent_tdr_data_ctrl_w3 #(.DATA_WIDTH(3), .CNT_WIDTH(4)) dut (
        .ijtag_tck          (tck),
        .ijtag_reset        (rst),
        .ijtag_sel          (sel),
        .ijtag_ce           (ce),
        .ijtag_se           (se),
        .ijtag_ue           (ue),
        .ijtag_si           (si),
        .ijtag_so           (so),
        .functional_data_in (fdi),
        .ijtag_data_out     (dout),
        .ijtag_select       (isel),
        .length_error       (lerr),
        .dbg_state          (st)
    );

    always #5 tck = ~tck;

    // One tck cycle with the given enables; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic c, input logic s, input logic u, input logic d);
        ce = c; se = s; ue = u; si = d;
        @(posedge tck);
        #1;
        ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_so, input logic e_isel,
                             input logic [2:0] e_dout, input logic e_lerr, input logic [1:0] e_st);
        check({tag, ".so"}, {7'd0, so}, {7'd0, e_so});
        check({tag, ".select"}, {7'd0, isel}, {7'd0, e_isel});
        check({tag, ".data"}, {5'd0, dout}, {5'd0, e_dout});
        check({tag, ".lerr"}, {7'd0, lerr}, {7'd0, e_lerr});
        check({tag, ".state"}, {6'd0, st}, {6'd0, e_st});
    endtask

    initial begin
        rst = 1'b1; sel = 1'b1; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0; fdi = 3'b000;
        @(posedge tck); #1;
        @(posedge tck); #1;
        rst = 1'b0;
        repeat (5) cyc(0, 0, 0, 0);
        check_all("reset", 0, 0, 3'b000, 0, ST_IDLE);

        // Capture 101: so shows status bit then data LSB first.
        fdi = 3'b101;
        cyc(1, 0, 0, 0);
        check_all("cap101", 0, 0, 3'b000, 0, ST_CAP);
        cyc(0, 1, 0, 0); check("sh1.so", {7'd0, so}, 8'd1);
        cyc(0, 1, 0, 0); check("sh2.so", {7'd0, so}, 8'd0);
        cyc(0, 1, 0, 0); check("sh3.so", {7'd0, so}, 8'd1);
        cyc(0, 1, 0, 0);
        check_all("sh4", 0, 0, 3'b000, 0, ST_SH);
        cyc(0, 0, 0, 0); check("so_hold", {7'd0, so}, 8'd0);

        // Valid update: shift in 1,1,0,1 -> select=1, data=101.
        fdi = 3'b010;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 1);
        check("pre_upd.select", {7'd0, isel}, 8'd0);
        cyc(0, 0, 1, 0);
        check_all("upd_ok", 1, 1, 3'b101, 0, ST_IDLE);

        // Short scan: update rejected, error reported and read-cleared by next capture.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        check_all("upd_short", 0, 1, 3'b101, 1, ST_IDLE);
        fdi = 3'b011;
        cyc(1, 0, 0, 0);
        check_all("cap_status", 1, 1, 3'b101, 0, ST_CAP);

        // Update straight from CAPTURED is an error.
        cyc(0, 0, 1, 0);
        check_all("upd_from_cap", 1, 1, 3'b101, 1, ST_IDLE);

        // ce+ue collision: capture wins (status = old error 1), error stays set.
        fdi = 3'b110;
        cyc(1, 0, 1, 0);
        check_all("ce_ue", 1, 1, 3'b101, 1, ST_CAP);
        cyc(1, 0, 0, 0);
        check_all("cap_clr", 1, 1, 3'b101, 0, ST_CAP);

        // se+ue collision: shift happens, error set, no update.
        cyc(0, 1, 1, 1);
        check_all("se_ue", 0, 1, 3'b101, 1, ST_SH);

        // Deselected: every enable ignored.
        sel = 1'b0;
        fdi = 3'b001;
        cyc(1, 1, 1, 1);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        check_all("desel", 0, 1, 3'b101, 1, ST_SH);
        sel = 1'b1;

        // Reset in the middle of a scan.
        fdi = 3'b111;
        cyc(1, 0, 0, 0);
        check_all("cap111", 1, 1, 3'b101, 0, ST_CAP);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        rst = 1'b1; se = 1'b1;
        @(posedge tck); #1;
        rst = 1'b0; se = 1'b0;
        check_all("mid_reset", 0, 0, 3'b000, 0, ST_IDLE);
        cyc(0, 0, 1, 0);
        check_all("ue_no_cap", 0, 0, 3'b000, 1, ST_IDLE);

        // Counter saturation: 20 shifts must not alias to a valid length.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 1);
        check("sat.so", {7'd0, so}, 8'd1);
        cyc(0, 0, 1, 0);
        check_all("upd_sat", 1, 0, 3'b000, 1, ST_IDLE);

        // Recovery: a correct-length scan after errors updates normally (select=0, data=011).
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        check_all("upd_recover", 0, 0, 3'b011, 0, ST_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
